// File: rtl/apb4_master_mc.sv
// apb4_master_mc: single-outstanding APB4 master. Decodes the target slave from the top
// address bits, bounds wait states with a timeout and returns a registered response.
module apb4_master_mc #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     preset,
  // command side
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  input  logic [DATA_W/8-1:0]      cmd_strb,
  // response side
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  // APB side
  output logic [NSLV-1:0]          psel,
  output logic                     penable,
  output logic [ADDR_W-1:0]        paddr,
  output logic                     pwrite,
  output logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W/8-1:0]      pstrb,
  input  logic [NSLV*DATA_W-1:0]   prdata,
  input  logic [NSLV-1:0]          pready,
  input  logic [NSLV-1:0]          pslverr
);

  localparam int SEL_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [SEL_W:0] NSLV_EXT   = (SEL_W + 1)'(NSLV);
  localparam logic [7:0]     WAIT_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;
  logic [NSLV-1:0]     r_psel;
  logic                r_penable;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [7:0]          r_wait_cnt;

  logic                w_accept;
  logic [SEL_W-1:0]    w_idx;
  logic                w_idx_ok;
  logic                w_sel_ready;
  logic                w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_wait_expired;

  assign w_accept = cmd_valid && r_cmd_ready;

  generate
    if (NSLV == 1) begin : g_single_slave
      assign w_idx = '0;
    end else begin : g_multi_slave
      assign w_idx = cmd_addr[ADDR_W-1 -: SEL_W];
    end
  endgenerate

  assign w_idx_ok = ({1'b0, w_idx} < NSLV_EXT);

  // psel is one-hot, so masking with it picks the selected slave's inputs only.
  assign w_sel_ready = |(pready & r_psel);
  assign w_sel_err   = |(pslverr & r_psel);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_psel[i]) w_sel_rdata = w_sel_rdata | prdata[i*DATA_W +: DATA_W];
    end
  end

  assign w_wait_expired = (r_wait_cnt == WAIT_LIMIT);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && w_idx_ok) w_next_state = S_SETUP;
      S_SETUP:  w_next_state = S_ACCESS;
      S_ACCESS: if (w_sel_ready || w_wait_expired) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_psel        <= '0;
      r_penable     <= 1'b0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_wait_cnt    <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_cmd_ready <= (w_next_state == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_idx_ok) begin
            r_paddr    <= cmd_addr;
            r_pwrite   <= cmd_write;
            r_pwdata   <= cmd_wdata;
            r_pstrb    <= cmd_write ? cmd_strb : '0;
            r_psel     <= NSLV'(1) << w_idx;
            r_penable  <= 1'b0;
            r_wait_cnt <= '0;
          end else if (w_accept) begin
            // Unmapped slave: answer immediately with a decode error, bus untouched.
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
          end
        end
        S_SETUP: r_penable <= 1'b1;
        S_ACCESS: begin
          // pready wins over an expiring wait counter in the same cycle.
          if (w_sel_ready) begin
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= w_sel_err;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= r_pwrite ? '0 : w_sel_rdata;
          end else if (w_wait_expired) begin
            r_psel        <= '0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign psel        = r_psel;
  assign penable     = r_penable;
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;

endmodule

// File: tb/tb_apb4_master_mc.sv
// tb_apb4_master_mc: randomized scoreboard bench for apb4_master_mc (3 slaves, TIMEOUT 4)
// with a responder that plans each transfer's wait states and response.
module tb_apb4_master_mc;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NSLV    = 3;
  localparam int TIMEOUT = 4;
  localparam int STRB_W  = DATA_W / 8;
  localparam int NEVER   = 1000;

  logic                   pclk = 1'b0;
  logic                   preset = 1'b1;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic                   cmd_write = 1'b0;
  logic [ADDR_W-1:0]      cmd_addr = '0;
  logic [DATA_W-1:0]      cmd_wdata = '0;
  logic [STRB_W-1:0]      cmd_strb = '0;
  logic                   rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   rsp_timeout;
  logic [NSLV-1:0]        psel;
  logic                   penable;
  logic [ADDR_W-1:0]      paddr;
  logic                   pwrite;
  logic [DATA_W-1:0]      pwdata;
  logic [STRB_W-1:0]      pstrb;
  logic [NSLV*DATA_W-1:0] prdata = '0;
  logic [NSLV-1:0]        pready = '0;
  logic [NSLV-1:0]        pslverr = '0;

  apb4_master_mc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              tmo;
    int                edge_no;
  } rsp_t;

  typedef struct {
    logic [NSLV-1:0]   sel;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    int                cycles;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit hung  = 1'b0;

  // Plan for the transfer currently on the bus.
  int                p_waits   = 0;
  logic              p_slverr  = 1'b0;
  logic [DATA_W-1:0] p_rdata   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  // Reference model: outcome of one command from the protocol rules alone.
  task automatic predict(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input logic [STRB_W-1:0] strb, input int waits, input logic slverr,
                         input logic [DATA_W-1:0] rdata, input int accept_edge);
    int   idx;
    rsp_t r;
    bus_t b;
    idx = int'(addr[ADDR_W-1 -: 2]);
    if (idx >= NSLV) begin
      r.rdata = '0; r.err = 1'b1; r.tmo = 1'b0; r.edge_no = accept_edge;
      rsp_q.push_back(r);
      return;
    end
    if (waits >= TIMEOUT) begin
      r.rdata = '0; r.err = 1'b1; r.tmo = 1'b1;
      r.edge_no = accept_edge + 1 + TIMEOUT;
      b.cycles  = 1 + TIMEOUT;
    end else begin
      r.rdata = wr ? '0 : rdata; r.err = slverr; r.tmo = 1'b0;
      r.edge_no = accept_edge + 2 + waits;
      b.cycles  = 2 + waits;
    end
    b.sel = '0;
    b.sel[idx] = 1'b1;
    b.addr = addr; b.wr = wr; b.wdata = wdata; b.strb = wr ? strb : '0;
    rsp_q.push_back(r);
    bus_q.push_back(b);
  endtask

  // Slave responder: junk everywhere, planned answer from the selected slave.
  int acc_k = 0;
  always @(negedge pclk) begin
    prdata  = {$urandom, $urandom, $urandom};
    pready  = NSLV'($urandom);
    pslverr = NSLV'($urandom);
    if (preset && psel != '0 && penable) begin
      for (int i = 0; i < NSLV; i++) begin
        if (psel[i]) begin
          pready[i]  = (acc_k == p_waits);
          if (acc_k == p_waits) begin
            pslverr[i] = p_slverr;
            prdata[i*DATA_W +: DATA_W] = p_rdata;
          end
        end
      end
      acc_k++;
    end else begin
      acc_k = 0;
    end
  end

  // Response monitor.
  logic [DATA_W+1:0] last_rsp = '0;
  always @(negedge pclk) begin
    rsp_t e;
    if (!preset) begin
      last_rsp = '0;
    end else if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        e = rsp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        check("rsp_latency", 64'(cyc), 64'(e.edge_no));
      end
      last_rsp = {rsp_err, rsp_timeout, rsp_rdata};
    end else begin
      check("rsp_hold", 64'({rsp_err, rsp_timeout, rsp_rdata}), 64'(last_rsp));
    end
  end

  // Bus monitor.
  bus_t cur_bus;
  int   bus_cnt = 0;
  bit   bus_active = 1'b0;
  always @(negedge pclk) begin
    if (!preset) begin
      bus_active = 1'b0;
    end else if (psel != '0) begin
      if (!bus_active) begin
        bus_active = 1'b1;
        bus_cnt = 0;
        if (bus_q.size() == 0) begin
          fail_now("bus_unexpected");
          cur_bus.sel = '0; cur_bus.addr = '0; cur_bus.wr = 1'b0;
          cur_bus.wdata = '0; cur_bus.strb = '0; cur_bus.cycles = 0;
        end else begin
          cur_bus = bus_q.pop_front();
        end
        check("penable_setup", 64'(penable), 64'd0);
      end else begin
        check("penable_access", 64'(penable), 64'd1);
      end
      check("psel", 64'(psel), 64'(cur_bus.sel));
      check("paddr", 64'(paddr), 64'(cur_bus.addr));
      check("pwrite", 64'(pwrite), 64'(cur_bus.wr));
      check("pwdata", 64'(pwdata), 64'(cur_bus.wdata));
      check("pstrb", 64'(pstrb), 64'(cur_bus.strb));
      bus_cnt++;
    end else if (bus_active) begin
      bus_active = 1'b0;
      check("psel_cycles", 64'(bus_cnt), 64'(cur_bus.cycles));
      check("penable_idle", 64'(penable), 64'd0);
    end
  end

  // Issue one command: junk (possibly valid) while busy, then present it when cmd_ready is high.
  task automatic send(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                      input logic [STRB_W-1:0] strb, input int waits, input logic slverr,
                      input logic [DATA_W-1:0] rdata);
    int budget;
    if (hung) return;
    budget = 0;
    @(negedge pclk);
    while (!cmd_ready) begin
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_strb  = STRB_W'($urandom);
      budget++;
      if (budget > 64) begin
        fail_now("cmd_ready_wait_expired");
        hung = 1'b1;
        cmd_valid = 1'b0;
        return;
      end
      @(negedge pclk);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    p_waits   = waits;
    p_slverr  = slverr;
    p_rdata   = rdata;
    predict(wr, addr, wdata, strb, waits, slverr, rdata, cyc + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"}, 64'(psel), 64'd0);
    check({tag, "_penable"}, 64'(penable), 64'd0);
    check({tag, "_paddr"}, 64'(paddr), 64'd0);
    check({tag, "_pwrite"}, 64'(pwrite), 64'd0);
    check({tag, "_pwdata"}, 64'(pwdata), 64'd0);
    check({tag, "_pstrb"}, 64'(pstrb), 64'd0);
    check({tag, "_rsp"}, 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  initial begin
    #1 preset = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge pclk);
    preset = 1'b1;
    #1 check("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge pclk);
    #1 check("ready_after_edge", 64'(cmd_ready), 64'd1);

    // Directed corners.
    send(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
    send(1'b0, 32'h8000_0020, 32'hCAFE_F00D, 4'h5, 3, 1'b0, 32'h1234_5678);
    send(1'b1, 32'h0000_0100, 32'h0BAD_0BAD, 4'h3, 0, 1'b1, 32'h0);
    send(1'b0, 32'h4000_0200, 32'h0, 4'h0, NEVER, 1'b0, 32'h5555_AAAA);
    send(1'b1, 32'hC000_0000, 32'h1111_2222, 4'hF, 0, 1'b0, 32'h0);
    send(1'b0, 32'h0000_0004, 32'h0, 4'hF, 2, 1'b1, 32'h9ABC_DEF0);

    // Reset while the selected slave is inserting wait states.
    send(1'b0, 32'h4000_0040, 32'h0, 4'h0, NEVER, 1'b0, 32'h0);
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    check("access_before_reset", 64'({psel, penable}), 64'({3'b010, 1'b1}));
    #2 preset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    rsp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge pclk);
    preset = 1'b1;
    #1 check("mid_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge pclk);
    #1 check("mid_ready_after_edge", 64'(cmd_ready), 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      logic [ADDR_W-1:0] a;
      int                w;
      a = {2'($urandom_range(0, 3)), 30'($urandom)};
      w = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 5));
      send(1'($urandom), a, $urandom, STRB_W'($urandom), w, 1'($urandom), $urandom);
    end
    @(negedge pclk);
    cmd_valid = 1'b0;

    for (int k = 0; k < 40 && (rsp_q.size() != 0 || bus_active); k++) @(negedge pclk);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    check("bus_queue_drained", 64'(bus_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb4_master_mc.md
APB4_MASTER_MC -- requirements
Module: apb4_master_mc

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning APB address width.
REQ-002 SHALL have parameter DATA_W, default 32 (legal 8/16/32), meaning APB data width.
REQ-003 SHALL have parameter NSLV, default 4 (legal 1..16), meaning number of APB slaves.
REQ-004 SHALL have parameter TIMEOUT, default 16 (legal 1..255), meaning the maximum number of ACCESS cycles allowed per transfer.
REQ-005 SHALL define SEL_W = max(1, clog2(NSLV)) and STRB_W = DATA_W/8 as local widths.
REQ-006 SHALL have port pclk, input, 1, the only clock; all logic samples on its rising edge.
REQ-007 SHALL have port preset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1 = write); cmd_addr in ADDR_W; cmd_wdata in DATA_W; cmd_strb in STRB_W.
REQ-009 SHALL have ports rsp_valid out 1; rsp_rdata out DATA_W; rsp_err out 1; rsp_timeout out 1.
REQ-010 SHALL have ports psel out NSLV (one-hot); penable out 1; paddr out ADDR_W; pwrite out 1; pwdata out DATA_W; pstrb out STRB_W.
REQ-011 SHALL have ports prdata in NSLV*DATA_W (slave i occupies bits [i*DATA_W +: DATA_W]); pready in NSLV; pslverr in NSLV.

Function
REQ-012 SHALL implement the states IDLE, SETUP and ACCESS, with all outputs driven from registers.
REQ-013 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted when cmd_valid && cmd_ready are both high at a clock edge.
REQ-014 SHALL decode the slave index as idx = cmd_addr[ADDR_W-1 -: SEL_W] (idx = 0 when NSLV = 1).
REQ-015 SHALL, on accepting a command with idx < NSLV:
- register paddr, pwrite and pwdata from the command;
- register pstrb = cmd_strb on a write and 0 on a read;
- set psel[idx] = 1 with penable = 0;
- enter SETUP.
REQ-016 SHALL, on accepting a command with idx >= NSLV:
- keep psel at all zeros and return to IDLE;
- produce a decode error response on the next cycle: rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
REQ-017 SHALL move from SETUP to ACCESS unconditionally after one cycle, setting penable = 1.
REQ-018 SHALL hold paddr, pwrite, pwdata, pstrb and psel stable from SETUP through the end of ACCESS.
REQ-019 SHALL, in ACCESS, sample only the selected slave's pready, pslverr and prdata; inputs of non-selected slaves are ignored.
REQ-020 SHALL, in ACCESS, increment an 8-bit wait counter on every cycle in which the selected pready = 0; the counter clears on entry to SETUP.
REQ-021 SHALL, on an ACCESS cycle in which the selected pready = 1:
- clear psel and penable at the next edge and return to IDLE;
- pulse rsp_valid for exactly one cycle;
- return rsp_err = selected pslverr and rsp_timeout = 0;
- return rsp_rdata = selected prdata on a read and 0 on a write.
REQ-022 SHALL abort the transfer when the wait counter reaches TIMEOUT-1 with pready still low:
- clear psel and penable and return to IDLE;
- pulse rsp_valid with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
REQ-023 SHALL give pready = 1 priority over timeout when both occur in the same cycle.
REQ-024 SHALL give zero-wait latency as: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid in cycle N+3, cmd_ready high again in cycle N+3.
REQ-025 SHALL hold rsp_rdata, rsp_err and rsp_timeout until the next response; rsp_valid is high for one cycle only and has no backpressure.
REQ-026 SHALL ignore cmd_* inputs while cmd_ready = 0; no command is queued.

Reset
REQ-027 SHALL, while preset = 0, immediately (without a clock edge) force:
- state to IDLE and the wait counter to 0;
- psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout and cmd_ready to 0;
- paddr, pwdata, pstrb and rsp_rdata to 0.
REQ-028 SHALL, when reset is asserted mid-transfer, drop the transfer with no response, and resume with cmd_ready = 1 on the first edge after preset rises.

Verification
REQ-029 SHALL cover a zero-wait write: cmd addr 0x4000_0010 (NSLV 4 gives idx 1), wdata 0xDEADBEEF, strb 0xF, with pready[1] = 1 -> psel = 0010 for 2 cycles, penable high in the 2nd, rsp_valid at N+3 with rsp_err = 0.
REQ-030 SHALL cover a read with 3 wait states: idx 2, pready[2] low for 3 ACCESS cycles, prdata slot 2 = 0x12345678 -> ACCESS lasts 4 cycles, rsp_rdata = 0x12345678, pstrb = 0 throughout.
REQ-031 SHALL cover a slave error: pslverr[0] = 1 with pready[0] = 1 on a write -> rsp_err = 1, rsp_timeout = 0.
REQ-032 SHALL cover a timeout: TIMEOUT = 4 with pready held at 0 -> psel drops after 4 ACCESS cycles, rsp_valid with rsp_err = 1, rsp_timeout = 1.
REQ-033 SHALL cover a decode error: NSLV = 3 with addr top bits = 2'b11 -> psel never asserted, rsp_err = 1 one cycle after accept.
REQ-034 SHALL cover reset in ACCESS: preset low mid-wait -> all outputs 0 asynchronously, no rsp_valid, cmd_ready = 1 one edge after release.
